// File: rtl/fifo_pkg.sv
// Shared FIFO types: the read-mode selector used by fifo_flex and by the
// UART TX/RX wrappers that instantiate it.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

endpackage

// File: rtl/simple_dual_port_ram_single_clock.sv
// Single-clock simple dual-port RAM: synchronous write, registered read with
// a read enable so the output word holds between reads.
module simple_dual_port_ram_single_clock #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 4
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_W)-1];

  // NOTE: the array is deliberately not reset so it maps onto block RAM;
  // only the read register below is reset.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)     o_rd_data <= '0;
    else if (i_re) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/fifo_flex.sv
// Parametrised single-clock FIFO: standard or first-word-fall-through read,
// occupancy and threshold flags, sticky error flags and synchronous flush.
module fifo_flex
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH    = 8,
  parameter int         DEPTH         = 16,
  parameter fifo_mode_e MODE          = FIFO_STD,
  parameter int         AFULL_THRESH  = DEPTH - 2,
  parameter int         AEMPTY_THRESH = 2,
  localparam int        ADDR_W        = $clog2(DEPTH)
)(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_clr_err,
  input  logic                  i_en_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_en_rd,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_rd_valid,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_W:0]       o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AFULL_C  = (ADDR_W+1)'(AFULL_THRESH);
  localparam logic [ADDR_W:0] AEMPTY_C = (ADDR_W+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W+1)'(1);
  localparam bit              IS_FWFT  = (MODE == FIFO_FWFT);

  logic [ADDR_W:0] wr_ptr, rd_ptr, count;
  logic            stage_valid, stage_valid_d;
  logic            std_valid;
  logic            wr_accept, rd_accept, wr_reject, rd_reject;
  logic            ram_re, ram_has_data;

  // In FWFT mode the RAM read register is the output stage; stage_valid
  // marks it as holding the head word, so rd_ptr runs ahead of the pops.
  assign o_fifo_full    = (count == DEPTH_C);
  assign o_fifo_empty   = IS_FWFT ? ~stage_valid : (count == '0);
  assign o_almost_full  = (count >= AFULL_C);
  assign o_almost_empty = (count <= AEMPTY_C);
  assign o_count        = count;
  assign o_rd_valid     = IS_FWFT ? stage_valid : std_valid;

  assign wr_accept    = i_en_wr & ~o_fifo_full  & ~i_flush;
  assign rd_accept    = i_en_rd & ~o_fifo_empty & ~i_flush;
  assign wr_reject    = i_en_wr &  o_fifo_full  & ~i_flush;
  assign rd_reject    = i_en_rd &  o_fifo_empty & ~i_flush;
  assign ram_has_data = (wr_ptr != rd_ptr);

  // NOTE: every output of this block gets a default first, so no path
  // through it can leave a value unassigned and infer a latch.
  always_comb begin
    ram_re        = 1'b0;
    stage_valid_d = stage_valid;
    if (IS_FWFT) begin
      ram_re = ~i_flush & ram_has_data & (~stage_valid | rd_accept);
      if (ram_re)         stage_valid_d = 1'b1;
      else if (rd_accept) stage_valid_d = 1'b0;
    end else begin
      ram_re = rd_accept;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      stage_valid <= 1'b0;
      std_valid   <= 1'b0;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + ONE;
      if (ram_re)    rd_ptr <= rd_ptr + ONE;
      unique case ({wr_accept, rd_accept})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
      stage_valid <= stage_valid_d;
      std_valid   <= rd_accept;
    end
  end

  // A new error in the same cycle as i_clr_err wins; flush leaves flags alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      o_overflow  <= (o_overflow  & ~i_clr_err) | wr_reject;
      o_underflow <= (o_underflow & ~i_clr_err) | rd_reject;
    end
  end

  simple_dual_port_ram_single_clock #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_we      (wr_accept),
    .i_wr_addr (wr_ptr[ADDR_W-1:0]),
    .i_wr_data (i_data),
    .i_re      (ram_re),
    .i_rd_addr (rd_ptr[ADDR_W-1:0]),
    .o_rd_data (o_data)
  );

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: a STD and a FWFT instance share stimulus; a queue model
// checks the selected instance every cycle, plus hand-computed literal checks.
module tb_fifo_flex;
  import fifo_pkg::*;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst, flush, clr, en_wr, en_rd;
  logic [7:0] din;
  logic       sel;      // 0: check the STD instance, 1: check the FWFT instance
  logic       chk_en;

  logic [7:0] s_data, f_data, d_data;
  logic [4:0] s_count, f_count, d_count;
  logic s_rv, s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic f_rv, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic d_rv, d_full, d_empty, d_af, d_ae, d_ovf, d_unf;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(DEPTH), .MODE(FIFO_STD),
              .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut_std (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr),
    .i_en_wr(en_wr), .i_data(din), .i_en_rd(en_rd),
    .o_data(s_data), .o_rd_valid(s_rv), .o_fifo_full(s_full),
    .o_fifo_empty(s_empty), .o_almost_full(s_af), .o_almost_empty(s_ae),
    .o_count(s_count), .o_overflow(s_ovf), .o_underflow(s_unf));

  fifo_flex #(.DATA_WIDTH(8), .DEPTH(DEPTH), .MODE(FIFO_FWFT),
              .AFULL_THRESH(14), .AEMPTY_THRESH(2)) dut_fwft (
    .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_clr_err(clr),
    .i_en_wr(en_wr), .i_data(din), .i_en_rd(en_rd),
    .o_data(f_data), .o_rd_valid(f_rv), .o_fifo_full(f_full),
    .o_fifo_empty(f_empty), .o_almost_full(f_af), .o_almost_empty(f_ae),
    .o_count(f_count), .o_overflow(f_ovf), .o_underflow(f_unf));

  assign d_data  = sel ? f_data  : s_data;
  assign d_count = sel ? f_count : s_count;
  assign d_rv    = sel ? f_rv    : s_rv;
  assign d_full  = sel ? f_full  : s_full;
  assign d_empty = sel ? f_empty : s_empty;
  assign d_af    = sel ? f_af    : s_af;
  assign d_ae    = sel ? f_ae    : s_ae;
  assign d_ovf   = sel ? f_ovf   : s_ovf;
  assign d_unf   = sel ? f_unf   : s_unf;

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0] d;
    int         wc;   // cycle in which the word was written
  } ent_t;

  ent_t       mq[$];
  int         cyc = 0;
  logic [7:0] m_data;
  logic       m_std_valid, m_ovf, m_unf;

  // FWFT: the head word is visible two cycles after the cycle it was written.
  function automatic bit m_empty(input int c);
    if (mq.size() == 0) return 1'b1;
    if (sel) return (mq[0].wc > c - 2);
    return 1'b0;
  endfunction

  task automatic model_update();
    bit   full, empty, wa, ra;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_data = 8'h00; m_std_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = m_empty(cyc);
      wa = en_wr && !full  && !flush;
      ra = en_rd && !empty && !flush;
      m_ovf = (m_ovf && !clr) || (en_wr && full  && !flush);
      m_unf = (m_unf && !clr) || (en_rd && empty && !flush);
      if (flush) begin
        mq.delete();
        m_std_valid = 1'b0;
      end else begin
        if (ra) begin
          e = mq.pop_front();
          m_data = e.d;
        end
        m_std_valid = ra;
        if (wa) begin
          e.d = din; e.wc = cyc;
          mq.push_back(e);
        end
      end
    end
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic compare_all();
    bit e;
    int n;
    n = mq.size();
    e = m_empty(cyc);
    check("m.count",        32'(d_count), n);
    check("m.full",         32'(d_full),  32'(n == DEPTH));
    check("m.almost_full",  32'(d_af),    32'(n >= 14));
    check("m.almost_empty", 32'(d_ae),    32'(n <= 2));
    check("m.empty",        32'(d_empty), 32'(e));
    check("m.overflow",     32'(d_ovf),   32'(m_ovf));
    check("m.underflow",    32'(d_unf),   32'(m_unf));
    if (!sel) begin
      check("m.rd_valid", 32'(d_rv),   32'(m_std_valid));
      check("m.data",     32'(d_data), 32'(m_data));
    end else begin
      check("m.rd_valid", 32'(d_rv), 32'(!e));
      if (!e) check("m.data", 32'(d_data), 32'(mq[0].d));
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_all();
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic wr, input logic [7:0] d, input logic rd,
                      input logic fl, input logic cl, input logic rs);
    en_wr = wr; din = d; en_rd = rd; flush = fl; clr = cl; rst = rs;
    @(posedge clk);
    model_update();
    #1;
    en_wr = 1'b0; en_rd = 1'b0; flush = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic rd();                    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic idle();                  step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic clear_err();             step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0); endtask
  task automatic do_reset();              step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1); endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".count"},        32'(d_count), 0);
    check({tag, ".empty"},        32'(d_empty), 1);
    check({tag, ".almost_empty"}, 32'(d_ae),    1);
    check({tag, ".full"},         32'(d_full),  0);
    check({tag, ".almost_full"},  32'(d_af),    0);
    check({tag, ".data"},         32'(d_data),  0);
    check({tag, ".rd_valid"},     32'(d_rv),    0);
    check({tag, ".overflow"},     32'(d_ovf),   0);
    check({tag, ".underflow"},    32'(d_unf),   0);
  endtask

  // Pops until the FIFO holds nothing; an exhausted budget counts as a failure.
  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (d_count == 0) break;
      step(1'b0, 8'h00, !d_empty, 1'b0, 1'b0, 1'b0);
    end
    check("drain.count", 32'(d_count), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    sel = 1'b0; chk_en = 1'b0;
    rst = 1'b1; flush = 1'b0; clr = 1'b0; en_wr = 1'b0; en_rd = 1'b0; din = 8'h00;

    // ===== STD mode =====
    do_reset();
    do_reset();
    chk_en = 1'b1;
    check_reset_values("std.reset");

    // Fill 0x00..0x0F, then one rejected write.
    for (int i = 0; i < 16; i++) wr(8'(i));
    check("std.fill.count", 32'(d_count), 16);
    check("std.fill.full",  32'(d_full),  1);
    wr(8'hAA);
    check("std.ovf.flag",  32'(d_ovf),   1);
    check("std.ovf.count", 32'(d_count), 16);

    // Drain: each word one cycle after its read.
    for (int i = 0; i < 16; i++) begin
      rd();
      check("std.drain.valid", 32'(d_rv),   1);
      check("std.drain.data",  32'(d_data), i);
    end
    idle();
    check("std.drain.empty", 32'(d_empty), 1);
    check("std.hold.valid",  32'(d_rv),    0);
    check("std.hold.data",   32'(d_data),  32'h0F);
    clear_err();
    check("std.clr.overflow", 32'(d_ovf), 0);

    // Wrap-around.
    for (int i = 0; i < 10; i++) wr(8'(8'h20 + i));
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < 12; i++) wr(8'(8'h30 + i));
    check("std.wrap.count", 32'(d_count), 12);
    for (int i = 0; i < 12; i++) begin
      rd();
      check("std.wrap.data",  32'(d_data),  32'h30 + i);
      check("std.wrap.count", 32'(d_count), 11 - i);
    end
    check("std.wrap.ovf", 32'(d_ovf), 0);
    check("std.wrap.unf", 32'(d_unf), 0);

    // Read+write when full, then when empty.
    for (int i = 0; i < 16; i++) wr(8'(8'h40 + i));
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("std.full_rw.count", 32'(d_count), 15);
    check("std.full_rw.ovf",   32'(d_ovf),   1);
    check("std.full_rw.data",  32'(d_data),  32'h40);
    drain();
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0);
    check("std.empty_rw.count", 32'(d_count), 1);
    check("std.empty_rw.unf",   32'(d_unf),   1);
    rd();
    check("std.empty_rw.data",  32'(d_data),  32'h77);
    clear_err();

    // Thresholds.
    for (int i = 0; i < 13; i++) wr(8'(8'h50 + i));
    check("std.af.at13", 32'(d_af), 0);
    wr(8'h5D);
    check("std.af.at14", 32'(d_af), 1);
    for (int i = 0; i < 11; i++) rd();
    check("std.ae.count3", 32'(d_count), 3);
    check("std.ae.at3",    32'(d_ae),    0);
    rd();
    check("std.ae.at2",    32'(d_ae),    1);

    // Flush with 5 stored words and a simultaneous write; sticky flag kept.
    drain();
    rd();
    check("std.unf.set", 32'(d_unf), 1);
    for (int i = 0; i < 5; i++) wr(8'(8'h60 + i));
    step(1'b1, 8'h99, 1'b0, 1'b1, 1'b0, 1'b0);
    check("std.flush.count", 32'(d_count), 0);
    check("std.flush.empty", 32'(d_empty), 1);
    check("std.flush.unf",   32'(d_unf),   1);
    clear_err();
    check("std.flush.clr", 32'(d_unf), 0);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    check("std.flush_rd.unf", 32'(d_unf), 0);

    // Reset mid-stream with a flag set.
    rd();
    for (int i = 0; i < 3; i++) wr(8'(8'h70 + i));
    rd();
    do_reset();
    check_reset_values("std.midreset");

    // ===== FWFT mode =====
    sel = 1'b1;
    do_reset();
    check_reset_values("fwft.reset");

    // Latency: write at T, visible at T+2, count 1 already at T+1.
    wr(8'h5A);
    check("fwft.lat.count1", 32'(d_count), 1);
    check("fwft.lat.empty1", 32'(d_empty), 1);
    idle();
    check("fwft.lat.empty2", 32'(d_empty), 0);
    check("fwft.lat.data2",  32'(d_data),  32'h5A);
    check("fwft.lat.valid2", 32'(d_rv),    1);
    rd();
    check("fwft.pop.empty", 32'(d_empty), 1);

    // Streaming: one write and one pop per cycle, no gaps.
    for (int i = 0; i < 20; i++) begin
      if (i >= 2) begin
        check("fwft.stream.data",  32'(d_data),  32'h10 + i - 2);
        check("fwft.stream.empty", 32'(d_empty), 0);
      end
      step(1'b1, 8'(8'h10 + i), (i >= 2), 1'b0, 1'b0, 1'b0);
    end
    check("fwft.stream.count", 32'(d_count), 2);
    drain();

    // Full capacity is DEPTH including the staged word.
    for (int i = 0; i < 16; i++) wr(8'(8'h80 + i));
    check("fwft.fill.count", 32'(d_count), 16);
    check("fwft.fill.full",  32'(d_full),  1);
    check("fwft.fill.head",  32'(d_data),  32'h80);
    step(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fwft.full_rw.count", 32'(d_count), 15);
    check("fwft.full_rw.ovf",   32'(d_ovf),   1);
    check("fwft.full_rw.head",  32'(d_data),  32'h81);
    drain();
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fwft.empty_rw.count", 32'(d_count), 1);
    check("fwft.empty_rw.unf",   32'(d_unf),   1);

    // Flush with a staged word and a simultaneous pop and write.
    for (int i = 0; i < 3; i++) wr(8'(8'h90 + i));
    idle();
    idle();
    step(1'b1, 8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    check("fwft.flush.count", 32'(d_count), 0);
    check("fwft.flush.empty", 32'(d_empty), 1);
    check("fwft.flush.valid", 32'(d_rv),    0);
    check("fwft.flush.unf",   32'(d_unf),   1);
    check("fwft.flush.ovf",   32'(d_ovf),   1);
    clear_err();
    check("fwft.clr.ovf", 32'(d_ovf), 0);
    check("fwft.clr.unf", 32'(d_unf), 0);
    wr(8'hD4);
    idle();
    check("fwft.post_flush.data", 32'(d_data), 32'hD4);
    idle();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
